// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set, 32-byte-line write-back cache datapath.
// Optional hit/miss performance counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int s_index = 3,
  parameter int s_tag   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  output logic              mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  input  logic              pmem_resp,
  input  logic [s_tag-1:0]  tag1,
  input  logic [s_tag-1:0]  tag2,
  input  logic [1:0]        valid,
  input  logic              dirty_bit1,
  input  logic              dirty_bit2,
  input  logic              lru,
  output logic              tag_load_1,
  output logic              tag_load_2,
  output logic              dirty_load_1,
  output logic              dirty_load_2,
  output logic              lru_load,
  output logic              valid_load,
  output logic              dirty_datain_1,
  output logic              dirty_datain_2,
  output logic              lru_datain,
  output logic [1:0]        valid_in,
  output logic [1:0]        data1_write_en_sel,
  output logic [1:0]        data2_write_en_sel,
  output logic              data1_datain_sel,
  output logic              data2_datain_sel,
  output logic              data_way_sel,
  output logic              pmem_address_sel,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;

  logic             req;
  logic [s_tag-1:0] addr_tag;
  logic             hit1, hit2, hit_any;
  logic             victim_dirty;

  // Index and offset are consumed by the datapath, not by this controller.
  logic [31-s_tag:0] unused_addr;
  assign unused_addr = mem_address[31-s_tag:0];

  assign req      = mem_read | mem_write;
  assign addr_tag = mem_address[31 -: s_tag];
  assign hit1     = valid[0] & (tag1 == addr_tag);
  assign hit2     = valid[1] & (tag2 == addr_tag);
  assign hit_any  = hit1 | hit2;
  assign victim_dirty = lru ? (valid[1] & dirty_bit2) : (valid[0] & dirty_bit1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = COMPARE;
      end
      COMPARE: begin
        if (!req || hit_any) begin
          state_d = IDLE;
        end else begin
          victim_d = lru;
          state_d  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        if (pmem_resp) state_d = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_resp           = 1'b0;
    pmem_read          = 1'b0;
    pmem_write         = 1'b0;
    tag_load_1         = 1'b0;
    tag_load_2         = 1'b0;
    dirty_load_1       = 1'b0;
    dirty_load_2       = 1'b0;
    lru_load           = 1'b0;
    valid_load         = 1'b0;
    dirty_datain_1     = 1'b0;
    dirty_datain_2     = 1'b0;
    lru_datain         = 1'b0;
    valid_in           = 2'b00;
    data1_write_en_sel = 2'b00;
    data2_write_en_sel = 2'b00;
    data1_datain_sel   = 1'b0;
    data2_datain_sel   = 1'b0;
    data_way_sel       = 1'b0;
    pmem_address_sel   = 1'b0;
    unique case (state_q)
      IDLE: ;
      COMPARE: begin
        // Way 1 takes priority if both ways claim the tag.
        if (req && hit_any) begin
          mem_resp     = 1'b1;
          data_way_sel = ~hit1;
          lru_load     = 1'b1;
          lru_datain   = hit1;
          if (mem_write) begin
            if (hit1) begin
              data1_write_en_sel = 2'b01;
              dirty_load_1       = 1'b1;
              dirty_datain_1     = 1'b1;
            end else begin
              data2_write_en_sel = 2'b01;
              dirty_load_2       = 1'b1;
              dirty_datain_2     = 1'b1;
            end
          end
        end
      end
      WRITEBACK: begin
        pmem_write       = 1'b1;
        pmem_address_sel = 1'b1;
        data_way_sel     = victim_q;
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          valid_load = 1'b1;
          valid_in   = valid | (victim_q ? 2'b10 : 2'b01);
          if (victim_q) begin
            data2_write_en_sel = 2'b10;
            data2_datain_sel   = 1'b1;
            tag_load_2         = 1'b1;
            dirty_load_2       = 1'b1;
          end else begin
            data1_write_en_sel = 2'b10;
            data1_datain_sel   = 1'b1;
            tag_load_1         = 1'b1;
            dirty_load_1       = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  // missed_q marks the re-COMPARE after a fill so it is not counted again.
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic        missed_q, missed_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    missed_d   = missed_q;
    if (state_q == COMPARE && req) begin
      if (hit_any) begin
        if (!missed_q) hit_cnt_d = hit_cnt_q + 32'd1;
        missed_d = 1'b0;
      end else begin
        if (!missed_q) miss_cnt_d = miss_cnt_q + 32'd1;
        missed_d = 1'b1;
      end
    end else if (state_q == IDLE) begin
      missed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
      missed_q   <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      missed_q   <= missed_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = 32'h0;
  assign miss_count = 32'h0;
`endif

endmodule

// File: doc/cache_control.md
# cache_control

Control FSM for the 2-way, 8-set, 32-byte-line write-back cache datapath. It accepts one CPU-side 256-bit request at a time, checks both ways for a hit, and sequences dirty-victim writeback and line fill over the physical-memory port. It drives every load, select and write-enable input of the datapath and consumes the datapath's tag, valid, dirty and LRU outputs. It sits between the cache bus adapter/requester and the datapath, one instance per cache.

## Interface
Parameters:
- s_index, 3, set-index width; index = mem_address[7:5]
- s_tag, 24, tag width; tag = mem_address[31:8]

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- mem_read, mem_write  in  1 each  CPU request strobes; held with mem_address until mem_resp
- mem_address  in  32  CPU address; only [31:8] used here
- mem_resp  out  1  one-cycle request completion
- pmem_read, pmem_write  out  1 each  physical-memory strobes; held until pmem_resp
- pmem_resp  in  1  physical-memory completion
- tag1, tag2  in  24 each  stored tags, way 1/2
- valid  in  2  valid bits; [0]=way 1, [1]=way 2
- dirty_bit1, dirty_bit2  in  1 each  dirty bits
- lru  in  1  victim way for this set: 0=way 1, 1=way 2
- tag_load_1, tag_load_2, dirty_load_1, dirty_load_2, lru_load, valid_load  out  1 each  array load strobes
- dirty_datain_1, dirty_datain_2, lru_datain  out  1 each  array write data
- valid_in  out  2  new valid vector
- data1_write_en_sel, data2_write_en_sel  out  2 each  00 none, 01 CPU byte enables, 10 all 32 bytes
- data1_datain_sel, data2_datain_sel  out  1 each  0 mem_wdata256, 1 pmem_rdata
- data_way_sel  out  1  0 way 1, 1 way 2; selects data_way_out
- pmem_address_sel  out  1  0 {mem_address[31:5],5'b0}, 1 {victim tag, index, 5'b0}
- hit_count, miss_count  out  32 each  performance counters (see Configuration)

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE: outputs inactive. mem_read|mem_write -> COMPARE. This gives the arrays one cycle to present the indexed set.
- COMPARE: hitN = valid[N-1] & (tagN == mem_address[31:8]).
  - Hit: assert mem_resp. data_way_sel = hit way. lru_load=1, lru_datain = other way. On write: dataN_write_en_sel=01, dataN_datain_sel=0, dirty_load_N=1, dirty_datain_N=1. Next state is IDLE.
  - Miss: victim = lru. Victim valid and dirty -> WRITEBACK; else -> FILL.
- WRITEBACK: pmem_write=1, pmem_address_sel=1, data_way_sel=victim. On pmem_resp -> FILL.
- FILL: pmem_read=1, pmem_address_sel=0. On pmem_resp, in the same cycle: victim write_en_sel=10, datain_sel=1, tag_load=1, dirty_load=1 with datain 0, valid_load=1, valid_in = valid | victim bit. Next state is COMPARE, which now hits; a write then merges its bytes and sets dirty.
- mem_read and mem_write both asserted: treated as a write.
- Both ways hit (corrupt state): way 1 wins.
- Outputs not named for a state are 0.

## Timing
- Reset: state=IDLE. All outputs 0, including counters.
- Reset mid-operation: the FSM aborts immediately; any pmem transaction is abandoned with no array writes.
- Hit latency: mem_resp 2 cycles after the request first appears (IDLE, then COMPARE).
- Clean miss: IDLE, COMPARE, FILL (≥1 cycle), COMPARE with mem_resp.
- Dirty miss: IDLE, COMPARE, WRITEBACK, FILL, COMPARE.
- pmem strobes: asserted from state entry and held until the cycle pmem_resp=1 inclusive. They drop the following cycle.
- mem_resp: exactly one cycle per request, never asserted outside COMPARE.
- pmem_resp in the same cycle a strobe is first asserted is accepted.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - hit_count increments once per request that hits on its first COMPARE.
  - miss_count increments once per request that misses on its first COMPARE.
  - The re-COMPARE after FILL is not counted (tracked with an internal missed flag).
  - Counters wrap at 2^32.
- CACHE_PERF_CNT_EN undefined: both ports tied to 32'h0 and no counter flops are inferred.

## Test plan
- Cold read 0x0000_0100, valid=00, lru=0 -> FILL with pmem_address 0x0000_0100. After pmem_resp: way-1 write_en_sel=10, valid_in=01. Then mem_resp. miss_count=1.
- Repeat read 0x0000_0100 -> mem_resp exactly 2 cycles after the request. lru_datain=1. hit_count=1.
- Write 0x0000_0120 with byte enable 0x0000_000F, hitting way 2 -> data2_write_en_sel=01, dirty_load_2=1 with datain 1, mem_resp in the same cycle.
- Read miss in set 1 where lru=1, way 2 dirty with tag 0xABCDEF -> WRITEBACK to 0xABCD_EF20, then FILL, then mem_resp. pmem_write and pmem_read never overlap.
- Assert rst during FILL with pmem_read=1 -> pmem_read, mem_resp and all load strobes go to 0 immediately. State is IDLE after release.
- With pmem_resp held 0 for 50 cycles in FILL -> pmem_read stays 1 throughout and no mem_resp occurs.
